// File: rtl/ram_seq_ctrl.sv
// Sequencer for the single-port BRAM counter demo: fills every word with an arithmetic pattern,
// then plays words back one per slow-tick rising edge. Optional macro: RAM_SEQ_DIR_EN (dir_in).
module ram_seq_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned INIT_VAL = 0,
  parameter int unsigned STEP     = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              start,
  input  logic              stop,
`ifdef RAM_SEQ_DIR_EN
  input  logic              dir_in,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StPlay = 2'd2,
    StWait = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] InitW    = DATA_W'(INIT_VAL);
  localparam logic [DATA_W-1:0] StepW    = DATA_W'(STEP);

  state_e            state;
  logic              tick_d;
  logic              tick_edge;
  logic [ADDR_W-1:0] play_next;

  assign tick_edge = tick_in & ~tick_d;
  assign busy      = (state != StIdle);
  assign state_o   = state;

  // Next playback address; wraps naturally in ADDR_W bits.
  always_comb begin
    play_next = ram_addr + ADDR_W'(1);
`ifdef RAM_SEQ_DIR_EN
    if (dir_in) begin
      play_next = ram_addr - ADDR_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= StIdle;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      tick_d     <= 1'b1;
    end else begin
      tick_d     <= tick_in;
      disp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          ram_we <= 1'b0;
          if (start && !stop) begin
            state     <= StFill;
            ram_addr  <= '0;
            ram_we    <= 1'b1;
            ram_wdata <= InitW;
          end
        end
        StFill: begin
          if (stop) begin
            state  <= StIdle;
            ram_we <= 1'b0;
          end else if (ram_addr == AddrLast) begin
            state    <= StPlay;
            ram_we   <= 1'b0;
            ram_addr <= '0;
          end else begin
            // Running sum equals INIT_VAL + addr*STEP modulo 2^DATA_W.
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= ram_wdata + StepW;
          end
        end
        StPlay: begin
          ram_we <= 1'b0;
          if (stop) begin
            state <= StIdle;
          end else if (tick_edge) begin
            state <= StWait;
          end
        end
        StWait: begin
          ram_we <= 1'b0;
          if (stop) begin
            state <= StIdle;
          end else begin
            disp_data  <= ram_rdata;
            disp_valid <= 1'b1;
            ram_addr   <= play_next;
            state      <= StPlay;
          end
        end
        default: begin
          state  <= StIdle;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Self-checking bench for ram_seq_ctrl: behavioural model plus directed scenarios on two instances
// (default parameters, and INIT_VAL=250/STEP=3 for the fill-wrap pattern).
module tb_ram_seq_ctrl;

  localparam int Depth = 16;
  localparam int PIdle = 0, PFill = 1, PPlay = 2, PWait = 3;
  localparam int P0Init = 0, P0Step = 1;
`ifdef RAM_SEQ_DIR_EN
  localparam bit DirEn = 1'b1;
`else
  localparam bit DirEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic dir_in = 1'b0;

  logic [3:0] addr0, addr1;
  logic       we0, we1, valid0, valid1, busy0, busy1;
  logic [7:0] wdata0, wdata1, rdata0, rdata1, disp0, disp1;
  logic [1:0] st0, st1;
  logic [7:0] mem0 [Depth];
  logic [7:0] mem1 [Depth];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int n_pulse = 0;
  int we_cnt = 0;
  bit lat_en = 1'b0;
  logic [7:0] dq[$];

  // Model state
  bit m_live = 1'b0;
  int ph = PIdle;
  int m_addr = 0;
  bit m_addr_known = 1'b0;
  bit m_wd_zero = 1'b0;
  logic [7:0] m_disp = 8'd0;
  bit m_valid = 1'b0;
  bit m_tick_prev = 1'b1;

  ram_seq_ctrl dut0 (
    .clk_in    (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .start     (start),
    .stop      (stop),
`ifdef RAM_SEQ_DIR_EN
    .dir_in    (dir_in),
`endif
    .ram_addr  (addr0),
    .ram_we    (we0),
    .ram_wdata (wdata0),
    .ram_rdata (rdata0),
    .disp_data (disp0),
    .disp_valid(valid0),
    .busy      (busy0),
    .state_o   (st0)
  );

  ram_seq_ctrl #(.ADDR_W(4), .DATA_W(8), .INIT_VAL(250), .STEP(3)) dut1 (
    .clk_in    (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .start     (start),
    .stop      (stop),
`ifdef RAM_SEQ_DIR_EN
    .dir_in    (dir_in),
`endif
    .ram_addr  (addr1),
    .ram_we    (we1),
    .ram_wdata (wdata1),
    .ram_rdata (rdata1),
    .disp_data (disp1),
    .disp_valid(valid1),
    .busy      (busy1),
    .state_o   (st1)
  );

  initial forever #5 clk = ~clk;

  // Single-port BRAMs with one-cycle registered read.
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wdata0;
    rdata0 <= mem0[addr0];
    if (we1) mem1[addr1] <= wdata1;
    rdata1 <= mem1[addr1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input int init, input int step, input int a);
    int v;
    v = (init + a * step) % 256;
    return v[7:0];
  endfunction

  // Behavioural model: evaluated once per clock edge from the sampled inputs.
  task automatic model_step();
    bit edge_s;
    edge_s      = tick_in && !m_tick_prev;
    m_tick_prev = tick_in;
    m_valid     = 1'b0;
    if (rst) begin
      m_live = 1'b1; ph = PIdle; m_addr = 0; m_addr_known = 1'b1;
      m_wd_zero = 1'b1; m_disp = 8'd0; m_tick_prev = 1'b1;
    end else if (m_live) begin
      case (ph)
        PIdle: if (start && !stop) begin
          ph = PFill; m_addr = 0; m_addr_known = 1'b1; m_wd_zero = 1'b0;
        end
        PFill: begin
          if (stop) begin ph = PIdle; m_addr_known = 1'b0; end
          else if (m_addr == Depth - 1) begin ph = PPlay; m_addr = 0; end
          else m_addr++;
        end
        PPlay: begin
          if (stop) begin ph = PIdle; m_addr_known = 1'b0; end
          else if (edge_s) ph = PWait;
        end
        default: begin
          if (stop) begin ph = PIdle; m_addr_known = 1'b0; end
          else begin
            m_disp  = pat(P0Init, P0Step, m_addr);
            m_valid = 1'b1;
            m_addr  = (DirEn && dir_in) ? (m_addr + Depth - 1) % Depth : (m_addr + 1) % Depth;
            ph      = PPlay;
          end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Compare process, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("state_o", 32'(st0), 32'(ph));
      chk("busy", 32'(busy0), 32'(ph != PIdle));
      chk("ram_we", 32'(we0), 32'(ph == PFill));
      if (m_addr_known) chk("ram_addr", 32'(addr0), 32'(m_addr));
      if (ph == PFill) chk("ram_wdata", 32'(wdata0), 32'(pat(P0Init, P0Step, m_addr)));
      else if (m_wd_zero) chk("ram_wdata_rst", 32'(wdata0), 32'd0);
      chk("disp_valid", 32'(valid0), 32'(m_valid));
      chk("disp_data", 32'(disp0), 32'(m_disp));
    end
    if (we0 === 1'b1) we_cnt++;
    if (valid0 === 1'b1) begin
      n_pulse++;
      dq.push_back(disp0);
      if (lat_en) chk("latency", 32'(cyc - rise_cyc), 32'd2);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    repeat (5) @(posedge clk);
    #1 tick_in = 1'b1;
    rise_cyc = cyc;
    repeat (5) @(posedge clk);
    #1 tick_in = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    int n = 0;
    while (32'(st0) != s && n < lim) begin
      cycle();
      n++;
    end
    chk(nm, 32'(st0), 32'(s));
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_state"}, 32'(st0), 32'd0);
    chk({nm, "_addr"}, 32'(addr0), 32'd0);
    chk({nm, "_we"}, 32'(we0), 32'd0);
    chk({nm, "_wdata"}, 32'(wdata0), 32'd0);
    chk({nm, "_disp"}, 32'(disp0), 32'd0);
    chk({nm, "_valid"}, 32'(valid0), 32'd0);
    chk({nm, "_busy"}, 32'(busy0), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    // Reset with tick_in already high.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("rst");
    chk("p1_disp_rst", 32'(disp1), 32'd0);
    chk("p1_valid_rst", 32'(valid1), 32'd0);
    repeat (3) cycle();
    tick_in = 1'b0;
    cycle();

    // start and stop together: stay idle.
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(st0), 32'd0);

    // Full fill.
    we_cnt = 0;
    pulse_start();
    wait_state(PPlay, 40, "fill_to_play");
    chk("fill_cycles", 32'(we_cnt), 32'd16);
    chk("play_we", 32'(we0), 32'd0);
    chk("p1_state", 32'(st1), 32'd2);
    chk("p1_busy", 32'(busy1), 32'd1);
    chk("p1_mem0", 32'(mem1[0]), 32'd250);
    chk("p1_mem1", 32'(mem1[1]), 32'd253);
    chk("p1_mem2", 32'(mem1[2]), 32'd0);
    chk("p1_mem3", 32'(mem1[3]), 32'd3);
    chk("p1_mem4", 32'(mem1[4]), 32'd6);
    chk("p1_mem15", 32'(mem1[15]), 32'd39);

    // 18 ticks with wraparound; start during PLAY must be ignored.
    lat_en = 1'b1;
    dq.delete();
    base = n_pulse;
    for (int i = 0; i < 18; i++) begin
      tick_once();
      if (i == 8) pulse_start();
    end
    repeat (3) cycle();
    chk("pulse_count", 32'(n_pulse - base), 32'd18);
    for (int i = 0; i < 18; i++) chk("play_seq", 32'(dq[i]), 32'(i % 16));

    // Stop from PLAY, restart, then stop at fill address 7.
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_play_state", 32'(st0), 32'd0);
    pulse_start();
    n = 0;
    while (!(st0 == 2'd1 && addr0 == 4'd7) && n < 40) begin
      cycle();
      n++;
    end
    chk("reach_addr7", 32'(addr0), 32'd7);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_fill_state", 32'(st0), 32'd0);
    chk("stop_fill_we", 32'(we0), 32'd0);
    chk("stop_fill_busy", 32'(busy0), 32'd0);
    base = n_pulse;
    repeat (6) cycle();
    chk("no_pulse_after_stop", 32'(n_pulse), 32'(base));

    // Reset in the middle of playback, with tick_in held high.
    pulse_start();
    wait_state(PPlay, 40, "refill_to_play");
    tick_once();
    tick_once();
    cycle();
    tick_in = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_values("midrst");
    pulse_start();
    wait_state(PPlay, 40, "post_rst_play");
    base = n_pulse;
    repeat (6) cycle();
    chk("held_tick_no_pulse", 32'(n_pulse), 32'(base));
    tick_in = 1'b0;

    dq.delete();
`ifdef RAM_SEQ_DIR_EN
    dir_in = 1'b1;
    for (int i = 0; i < 3; i++) tick_once();
    dir_in = 1'b0;
    for (int i = 0; i < 2; i++) tick_once();
    repeat (3) cycle();
    chk("dir_seq0", 32'(dq[0]), 32'd0);
    chk("dir_seq1", 32'(dq[1]), 32'd15);
    chk("dir_seq2", 32'(dq[2]), 32'd14);
    chk("dir_seq3", 32'(dq[3]), 32'd13);
    chk("dir_seq4", 32'(dq[4]), 32'd14);
`else
    for (int i = 0; i < 2; i++) tick_once();
    repeat (3) cycle();
    chk("restart_seq0", 32'(dq[0]), 32'd0);
    chk("restart_seq1", 32'(dq[1]), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Sequencer for the single-port BRAM counter demo.
- Fill phase: writes an arithmetic pattern into every BRAM word, one word per clk_in cycle.
- Playback phase: reads one word per rising edge of the slow tick from the clock divider (e.g. 10 Hz) and presents it to the display/LED stage.
- Owns all BRAM address, write-enable and write-data signals; the BRAM has no other master.

Parameters:
- ADDR_W, 4, BRAM address width; depth = 2^ADDR_W words.
- DATA_W, 8, BRAM word width.
- INIT_VAL, 0, value written to address 0 during fill.
- STEP, 1, increment between consecutive fill words.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- tick_in  input  1  slow clock level from the divider, synchronous to clk_in.
- start  input  1  begin fill then playback; sampled in IDLE only.
- stop  input  1  abort fill/playback, return to IDLE.
- ram_addr  output  ADDR_W  BRAM address.
- ram_we  output  1  BRAM write enable.
- ram_wdata  output  DATA_W  BRAM write data.
- ram_rdata  input  DATA_W  BRAM read data; 1-cycle registered read latency.
- disp_data  output  DATA_W  last word read in playback.
- disp_valid  output  1  one-cycle pulse when disp_data updates.
- busy  output  1  high in any state other than IDLE.
- state_o  output  2  current state encoding: IDLE=0, FILL=1, PLAY=2, WAIT=3.

Behaviour:
- Clocking and reset: one clock, clk_in; reset is synchronous and active-high (rst).
- Reset values: state IDLE, ram_addr 0, ram_we 0, ram_wdata 0, disp_data 0, disp_valid 0, busy 0, internal tick_d 1.
- Tick edge detection: tick_edge = tick_in & ~tick_d; tick_d <= tick_in every cycle.
  - tick_d resets to 1, so a tick_in already high after reset is not an edge.
  - An edge is seen at most once per rising edge of tick_in.
- IDLE:
  - ram_we 0.
  - start=1 and stop=0: ram_addr <= 0, go FILL.
  - start and stop both 1: stay IDLE.
- FILL:
  - ram_we 1 each cycle; ram_wdata = (INIT_VAL + ram_addr*STEP) mod 2^DATA_W, truncated to DATA_W.
  - ram_addr increments each cycle.
  - When the write at address 2^ADDR_W-1 is issued: next cycle ram_we 0, ram_addr 0, go PLAY.
  - Fill takes exactly 2^ADDR_W cycles. Ticks and start are ignored.
- PLAY:
  - ram_we 0.
  - On tick_edge: a read is issued at the current ram_addr (already driven), then go WAIT.
  - Otherwise hold.
- WAIT:
  - This is the cycle after issue; ram_rdata is valid.
  - disp_data <= ram_rdata and disp_valid pulses for 1 cycle.
  - ram_addr <= ram_addr+1, wrapping 2^ADDR_W-1 -> 0. Go PLAY.
  - A tick_edge in WAIT is dropped, not queued.
- Latency: tick_edge cycle -> disp_valid asserted 2 clk_in cycles after tick_in first samples high.
- stop (FILL/PLAY/WAIT):
  - Next state IDLE, ram_we 0 that cycle.
  - disp_data holds its last value; no disp_valid pulse.
  - A stop during FILL leaves the BRAM partially written.
- rst mid-operation: immediate return to reset values next edge; any pending read is discarded.
- start while busy is ignored.

Optional Feature:
- Macro: RAM_SEQ_DIR_EN.
- Defined: adds input port dir_in (1 bit). In WAIT, dir_in=1 decrements ram_addr with wrap 0 -> 2^ADDR_W-1; dir_in=0 increments. dir_in is sampled in the WAIT cycle; fill is unaffected.
- Undefined: port absent, playback always increments.

Test Plan:
- Reset, then start pulse with defaults -> ram_we high 16 consecutive cycles, ram_addr 0..15, ram_wdata 0..15, then state_o=2, ram_we 0.
- INIT_VAL=250, STEP=3, DATA_W=8 -> fill words 250, 253, 0, 3, ... (mod 256 wrap); address 15 holds (250+45) mod 256 = 39.
- After fill, 18 tick_in rising edges (tick 0 for 5 cycles, 1 for 5 cycles) -> 18 disp_valid pulses with disp_data 0..15, 0, 1 (wraparound). Each pulse occurs 2 cycles after tick_in rises.
- stop asserted at FILL address 7 -> state IDLE next cycle, ram_we 0, busy 0, disp_valid never pulses. Then rst mid-PLAY -> all outputs at reset values; tick_in held high produces no edge.
- start and stop high in the same IDLE cycle -> stays IDLE. start during PLAY -> ignored, address sequence continues.
- With RAM_SEQ_DIR_EN and dir_in=1 after fill -> disp_data sequence 0, 15, 14, ... Toggling dir_in to 0 mid-stream resumes incrementing from the current address.
